// File: rtl/pht_update_scheduler.sv
// Schedules PHT counter updates onto banked write ports: initializes the table
// after reset, then arbitrates branch-result updates with a deferred-update FIFO.
module pht_update_scheduler #(
  parameter int REQ_NUM     = 2,
  parameter int BANK_NUM    = 2,
  parameter int INDEX_WIDTH = 10,
  parameter int CTR_WIDTH   = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQ_NUM-1:0]                    reqValid,
  input  logic [REQ_NUM-1:0][INDEX_WIDTH-1:0]   reqIndex,
  input  logic [REQ_NUM-1:0]                    reqTaken,
  input  logic [REQ_NUM-1:0][CTR_WIDTH-1:0]     reqPrev,
  output logic [BANK_NUM-1:0]                   phtWE,
  output logic [BANK_NUM-1:0][INDEX_WIDTH-1:0]  phtWA,
  output logic [BANK_NUM-1:0][CTR_WIDTH-1:0]    phtWV,
  output logic                                  initDone,
  output logic [15:0]                           dropCount
);

  localparam int BANK_LOG = $clog2(BANK_NUM);
  localparam int BANK_W   = (BANK_LOG > 0) ? BANK_LOG : 1;
  localparam int GRP_W    = INDEX_WIDTH - BANK_LOG;
  localparam int PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(2 ** (CTR_WIDTH - 1));

  typedef enum logic {S_INIT, S_RUN} state_e;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic [CTR_WIDTH-1:0]   val;
  } entry_t;

  function automatic logic [BANK_W-1:0] bank_of(input logic [INDEX_WIDTH-1:0] idx);
    return BANK_W'(idx & INDEX_WIDTH'(BANK_NUM - 1));
  endfunction

  function automatic logic [CTR_WIDTH-1:0] next_ctr(input logic [CTR_WIDTH-1:0] prev,
                                                     input logic taken);
    if (taken) return (prev == CTR_MAX) ? prev : prev + CTR_WIDTH'(1);
    return (prev == '0) ? prev : prev - CTR_WIDTH'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    return PTR_W'((int'(p) + n) % QUEUE_DEPTH);
  endfunction

  state_e                              state_q, state_d;
  logic [GRP_W-1:0]                    init_idx_q, init_idx_d;
  entry_t                              fifo_q [QUEUE_DEPTH];
  entry_t                              fifo_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic [BANK_NUM-1:0]                 we_q, we_d;
  logic [BANK_NUM-1:0][INDEX_WIDTH-1:0] wa_q, wa_d;
  logic [BANK_NUM-1:0][CTR_WIDTH-1:0]  wv_q, wv_d;
  logic                                done_q, done_d;
  logic [15:0]                         drop_q, drop_d;

  logic [BANK_NUM-1:0]                 bank_busy;
  logic                                pop;
  entry_t                              head;
  logic [CTR_WIDTH-1:0]                nv;
  logic [BANK_W-1:0]                   rb;
  int                                  push_n;
  int                                  drop_n;
  int                                  free_n;
  int                                  drop_sum;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    we_d       = '0;
    wa_d       = wa_q;
    wv_d       = wv_q;
    drop_d     = drop_q;
    bank_busy  = '0;
    pop        = 1'b0;
    head       = '0;
    nv         = '0;
    rb         = '0;
    push_n     = 0;
    drop_n     = 0;
    free_n     = 0;
    drop_sum   = 0;

    // NOTE: blocking assignments here build a sequential allocation order
    // within one cycle; the registers below only ever use non-blocking ones.
    case (state_q)
      S_INIT: begin
        for (int b = 0; b < BANK_NUM; b++) begin
          we_d[b] = 1'b1;
          wa_d[b] = INDEX_WIDTH'(int'(init_idx_q) * BANK_NUM + b);
          wv_d[b] = CTR_WEAK;
        end
        init_idx_d = init_idx_q + GRP_W'(1);
        if (init_idx_q == '1) state_d = S_RUN;
      end

      S_RUN: begin
        // The oldest deferred update has first claim on its bank.
        if (count_q != '0) begin
          pop           = 1'b1;
          head          = fifo_q[rd_ptr_q];
          rb            = bank_of(head.idx);
          bank_busy[rb] = 1'b1;
          we_d[rb]      = 1'b1;
          wa_d[rb]      = head.idx;
          wv_d[rb]      = head.val;
          rd_ptr_d      = ptr_add(rd_ptr_q, 1);
        end

        free_n = QUEUE_DEPTH - int'(count_q) + int'(pop);
        for (int i = 0; i < REQ_NUM; i++) begin
          if (reqValid[i]) begin
            nv = next_ctr(reqPrev[i], reqTaken[i]);
            rb = bank_of(reqIndex[i]);
            if (!bank_busy[rb]) begin
              bank_busy[rb] = 1'b1;
              we_d[rb]      = 1'b1;
              wa_d[rb]      = reqIndex[i];
              wv_d[rb]      = nv;
            end else if (push_n < free_n) begin
              fifo_d[ptr_add(wr_ptr_q, push_n)] = '{idx: reqIndex[i], val: nv};
              push_n = push_n + 1;
            end else begin
              drop_n = drop_n + 1;
            end
          end
        end

        wr_ptr_d = ptr_add(wr_ptr_q, push_n);
        count_d  = CNT_W'(int'(count_q) - int'(pop) + push_n);
        drop_sum = int'(drop_q) + drop_n;
        drop_d   = (drop_sum > 65535) ? 16'hFFFF : 16'(drop_sum);
      end

      default: state_d = S_INIT;
    endcase

    done_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= '0;
      wa_q       <= '0;
      wv_q       <= '0;
      done_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wv_q       <= wv_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: FIFO storage has no reset; the occupancy counter alone decides
  // which entries are meaningful, so stale contents are never read.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign phtWE     = we_q;
  assign phtWA     = wa_q;
  assign phtWV     = wv_q;
  assign initDone  = done_q;
  assign dropCount = drop_q;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Self-checking bench for pht_update_scheduler: a queue-based reference model
// predicts the bank writes, initDone and dropCount for every cycle.
module tb_pht_update_scheduler;

  localparam int NR = 2;
  localparam int NB = 2;
  localparam int IW = 10;
  localparam int CW = 2;
  localparam int QD = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          reqValid;
  logic [NR-1:0][IW-1:0]  reqIndex;
  logic [NR-1:0]          reqTaken;
  logic [NR-1:0][CW-1:0]  reqPrev;
  logic [NB-1:0]          phtWE;
  logic [NB-1:0][IW-1:0]  phtWA;
  logic [NB-1:0][CW-1:0]  phtWV;
  logic                   initDone;
  logic [15:0]            dropCount;

  int errors = 0;
  int checks = 0;

  pht_update_scheduler #(
    .REQ_NUM(NR), .BANK_NUM(NB), .INDEX_WIDTH(IW), .CTR_WIDTH(CW), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqIndex(reqIndex), .reqTaken(reqTaken), .reqPrev(reqPrev),
    .phtWE(phtWE), .phtWA(phtWA), .phtWV(phtWV),
    .initDone(initDone), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  // Reference model: table-level behaviour with a plain queue of pending updates.
  typedef struct { int idx; int val; } ent_t;
  ent_t m_q[$];
  bit   m_run;
  int   m_grp;
  int   m_drops;
  bit   exp_we [NB];
  int   exp_wa [NB];
  int   exp_wv [NB];
  bit   exp_done;

  task automatic model_reset();
    m_q.delete();
    m_run = 0; m_grp = 0; m_drops = 0; exp_done = 0;
    for (int b = 0; b < NB; b++) begin exp_we[b] = 0; exp_wa[b] = 0; exp_wv[b] = 0; end
  endtask

  task automatic model_step();
    bit   busy [NB];
    ent_t e;
    int   nv, b;
    for (int k = 0; k < NB; k++) begin exp_we[k] = 0; busy[k] = 0; end
    if (!m_run) begin
      for (int k = 0; k < NB; k++) begin
        exp_we[k] = 1; exp_wa[k] = m_grp * NB + k; exp_wv[k] = 2 ** (CW - 1);
      end
      m_grp++;
      if (m_grp == (2 ** IW) / NB) m_run = 1;
    end else begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        b = e.idx % NB;
        busy[b] = 1; exp_we[b] = 1; exp_wa[b] = e.idx; exp_wv[b] = e.val;
      end
      for (int i = 0; i < NR; i++) begin
        if (reqValid[i]) begin
          nv = int'(reqPrev[i]) + (reqTaken[i] ? 1 : -1);
          if (nv < 0) nv = 0;
          if (nv > 2 ** CW - 1) nv = 2 ** CW - 1;
          b = int'(reqIndex[i]) % NB;
          if (!busy[b]) begin
            busy[b] = 1; exp_we[b] = 1; exp_wa[b] = int'(reqIndex[i]); exp_wv[b] = nv;
          end else if (m_q.size() < QD) begin
            e.idx = int'(reqIndex[i]); e.val = nv;
            m_q.push_back(e);
          end else if (m_drops < 65535) begin
            m_drops++;
          end
        end
      end
    end
    exp_done = m_run;
  endtask

  task automatic tick(input logic [NR-1:0] v, input logic [NR-1:0][IW-1:0] ix,
                      input logic [NR-1:0] tk, input logic [NR-1:0][CW-1:0] pv);
    reqValid = v; reqIndex = ix; reqTaken = tk; reqPrev = pv;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    reqValid = '1; reqIndex = '0; reqTaken = '0; reqPrev = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (phtWE !== '0 || initDone !== 1'b0 || dropCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got WE=%b done=%b drops=%0d exp WE=00 done=0 drops=0",
               phtWE, initDone, dropCount);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_init(input string tag);
    logic [NR-1:0][IW-1:0] ix;
    logic [NR-1:0][CW-1:0] pv;
    for (int c = 0; c < (2 ** IW) / NB + 3; c++) begin
      ix = '0; pv = '0;
      for (int i = 0; i < NR; i++) begin ix[i] = IW'($urandom); pv[i] = CW'($urandom); end
      if (c < (2 ** IW) / NB) tick(NR'($urandom), ix, NR'($urandom), pv);
      else tick('0, ix, '0, pv);
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (phtWE[b] !== exp_we[b]) begin
          errors++;
          $display("FAIL %s cyc=%0d we[%0d] got=%b exp=%b", tag, c, b, phtWE[b], exp_we[b]);
        end else if (exp_we[b]) begin
          checks++;
          if (phtWA[b] !== IW'(exp_wa[b]) || phtWV[b] !== CW'(exp_wv[b])) begin
            errors++;
            $display("FAIL %s cyc=%0d bank%0d got WA=%0d WV=%0d exp WA=%0d WV=%0d",
                     tag, c, b, phtWA[b], phtWV[b], exp_wa[b], exp_wv[b]);
          end
        end
      end
      checks++;
      if (initDone !== exp_done || dropCount !== 16'(m_drops)) begin
        errors++;
        $display("FAIL %s cyc=%0d got done=%b drops=%0d exp done=%b drops=%0d",
                 tag, c, initDone, dropCount, exp_done, m_drops);
      end
      if (c == 0) begin
        checks++;
        if (phtWE !== 2'b11 || phtWA[0] !== 10'd0 || phtWA[1] !== 10'd1 ||
            phtWV[0] !== 2'd2 || phtWV[1] !== 2'd2) begin
          errors++;
          $display("FAIL %s first_write got WE=%b WA0=%0d WA1=%0d exp WE=11 WA0=0 WA1=1 WV=2",
                   tag, phtWE, phtWA[0], phtWA[1]);
        end
      end
      if (c == (2 ** IW) / NB - 1) begin
        checks++;
        if (initDone !== 1'b1 || phtWA[1] !== 10'd1023) begin
          errors++;
          $display("FAIL %s last_write got done=%b WA1=%0d exp done=1 WA1=1023",
                   tag, initDone, phtWA[1]);
        end
      end
    end
  endtask

  task automatic test_directed();
    tick(2'b11, {10'd6, 10'd5}, 2'b01, {2'd0, 2'd3});
    checks++;
    if (phtWE !== 2'b11 || phtWA[1] !== 10'd5 || phtWV[1] !== 2'd3 ||
        phtWA[0] !== 10'd6 || phtWV[0] !== 2'd0) begin
      errors++;
      $display("FAIL dual_bank got WE=%b b1=%0d/%0d b0=%0d/%0d exp WE=11 b1=5/3 b0=6/0",
               phtWE, phtWA[1], phtWV[1], phtWA[0], phtWV[0]);
    end
    tick(2'b11, {10'd8, 10'd4}, 2'b11, {2'd1, 2'd1});
    checks++;
    if (phtWE !== 2'b01 || phtWA[0] !== 10'd4 || phtWV[0] !== 2'd2) begin
      errors++;
      $display("FAIL conflict_t1 got WE=%b WA0=%0d WV0=%0d exp WE=01 WA0=4 WV0=2",
               phtWE, phtWA[0], phtWV[0]);
    end
    tick('0, '0, '0, '0);
    checks++;
    if (phtWE !== 2'b01 || phtWA[0] !== 10'd8 || phtWV[0] !== 2'd2) begin
      errors++;
      $display("FAIL conflict_t2 got WE=%b WA0=%0d WV0=%0d exp WE=01 WA0=8 WV0=2",
               phtWE, phtWA[0], phtWV[0]);
    end
    tick('0, '0, '0, '0);
    checks++;
    if (phtWE !== 2'b00 || dropCount !== 16'd0) begin
      errors++;
      $display("FAIL conflict_idle got WE=%b drops=%0d exp WE=00 drops=0", phtWE, dropCount);
    end
  endtask

  // Each cycle offers two bank-0 updates; only one can be written directly.
  task automatic test_fifo_fill();
    logic [NR-1:0][IW-1:0] ix;
    logic [NR-1:0][CW-1:0] pv;
    for (int c = 0; c < 12; c++) begin
      ix = '0; pv = '0;
      for (int i = 0; i < NR; i++) begin
        ix[i] = IW'(2 * (c * NR + i) + 16); pv[i] = CW'($urandom);
      end
      if (c < 6) tick(2'b11, ix, NR'($urandom), pv);
      else tick('0, ix, '0, pv);
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (phtWE[b] !== exp_we[b]) begin
          errors++;
          $display("FAIL fifo_fill cyc=%0d we[%0d] got=%b exp=%b", c, b, phtWE[b], exp_we[b]);
        end else if (exp_we[b]) begin
          checks++;
          if (phtWA[b] !== IW'(exp_wa[b]) || phtWV[b] !== CW'(exp_wv[b])) begin
            errors++;
            $display("FAIL fifo_fill cyc=%0d bank%0d got WA=%0d WV=%0d exp WA=%0d WV=%0d",
                     c, b, phtWA[b], phtWV[b], exp_wa[b], exp_wv[b]);
          end
        end
      end
      checks++;
      if (dropCount !== 16'(m_drops)) begin
        errors++;
        $display("FAIL fifo_fill cyc=%0d drops got=%0d exp=%0d", c, dropCount, m_drops);
      end
      if (c == 3 || c == 5) begin
        checks++;
        if (dropCount !== ((c == 3) ? 16'd0 : 16'd2)) begin
          errors++;
          $display("FAIL fifo_drop_total cyc=%0d got=%0d exp=%0d", c, dropCount, (c == 3) ? 0 : 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    tick(2'b11, {10'd34, 10'd32}, 2'b11, {2'd0, 2'd0});
    tick(2'b11, {10'd38, 10'd36}, 2'b11, {2'd0, 2'd0});
    tick(2'b11, {10'd42, 10'd40}, 2'b11, {2'd0, 2'd0});
    #2 rst = 1'b0;
    #1;
    checks++;
    if (phtWE !== 2'b00 || initDone !== 1'b0 || dropCount !== 16'd0) begin
      errors++;
      $display("FAIL run_reset got WE=%b done=%b drops=%0d exp WE=00 done=0 drops=0",
               phtWE, initDone, dropCount);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    test_init("init_after_run_reset");
  endtask

  task automatic test_random();
    logic [NR-1:0][IW-1:0] ix;
    logic [NR-1:0][CW-1:0] pv;
    for (int c = 0; c < 400; c++) begin
      ix = '0; pv = '0;
      for (int i = 0; i < NR; i++) begin ix[i] = IW'($urandom); pv[i] = CW'($urandom); end
      tick(NR'($urandom), ix, NR'($urandom), pv);
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (phtWE[b] !== exp_we[b]) begin
          errors++;
          $display("FAIL random cyc=%0d we[%0d] got=%b exp=%b", c, b, phtWE[b], exp_we[b]);
        end else if (exp_we[b]) begin
          checks++;
          if (phtWA[b] !== IW'(exp_wa[b]) || phtWV[b] !== CW'(exp_wv[b])) begin
            errors++;
            $display("FAIL random cyc=%0d bank%0d got WA=%0d WV=%0d exp WA=%0d WV=%0d",
                     c, b, phtWA[b], phtWV[b], exp_wa[b], exp_wv[b]);
          end
        end
      end
      checks++;
      if (initDone !== exp_done || dropCount !== 16'(m_drops)) begin
        errors++;
        $display("FAIL random cyc=%0d got done=%b drops=%0d exp done=%b drops=%0d",
                 c, initDone, dropCount, exp_done, m_drops);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    #2 rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (100) tick('1, '0, '0, '0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (phtWE !== 2'b00 || initDone !== 1'b0) begin
      errors++;
      $display("FAIL init_reset got WE=%b done=%b exp WE=00 done=0", phtWE, initDone);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    test_init("init_after_init_reset");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init("init");
    test_directed();
    test_fifo_fill();
    test_reset_mid_run();
    test_random();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
PHT_UPDATE_SCHEDULER -- requirements
Module: pht_update_scheduler

Interface
REQ-001 The block SHALL have parameter REQ_NUM, default 2, meaning the number of branch-result update ports.
REQ-002 The block SHALL have parameter BANK_NUM, default 2 (power of two), meaning the number of PHT banks, with one write port per bank.
REQ-003 The block SHALL have parameter INDEX_WIDTH, default 10, meaning the PHT index width.
REQ-004 The block SHALL have parameter CTR_WIDTH, default 2, meaning the saturating counter width.
REQ-005 The block SHALL have parameter QUEUE_DEPTH, default 4 (power of two), meaning the number of deferred-update FIFO entries.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port reqValid[REQ_NUM], input, 1 bit each: update request valid.
REQ-009 The block SHALL have port reqIndex[REQ_NUM], input, INDEX_WIDTH bits each: PHT index (PC xor global history).
REQ-010 The block SHALL have port reqTaken[REQ_NUM], input, 1 bit each: resolved branch direction.
REQ-011 The block SHALL have port reqPrev[REQ_NUM], input, CTR_WIDTH bits each: counter value read at prediction time.
REQ-012 The block SHALL have port phtWE[BANK_NUM], output, 1 bit each: bank write enable.
REQ-013 The block SHALL have port phtWA[BANK_NUM], output, INDEX_WIDTH bits each: full write index.
REQ-014 The block SHALL have port phtWV[BANK_NUM], output, CTR_WIDTH bits each: write value.
REQ-015 The block SHALL have port initDone, output, 1 bit: high once PHT initialization completes.
REQ-016 The block SHALL have port dropCount, output, 16 bits: saturating count of discarded updates.

Function
REQ-017 The block SHALL select the bank as index[log2(BANK_NUM)-1:0].
REQ-018 The block SHALL implement a two-state FSM, INIT and RUN.
REQ-019 INIT SHALL write BANK_NUM consecutive indices per cycle, one per bank, starting at 0, each with value 2^(CTR_WIDTH-1) (weakly taken; 2 for the default), in ascending index order.
REQ-020 INIT SHALL last 2^INDEX_WIDTH/BANK_NUM cycles, then transition to RUN, with initDone rising in the first RUN cycle; RUN SHALL persist until reset.
REQ-021 In INIT, requests SHALL be ignored without incrementing dropCount, and the FIFO SHALL remain empty.
REQ-022 In RUN, each valid request SHALL produce a new value equal to reqPrev+1 if taken, or reqPrev-1 if not taken.
REQ-023 The new value SHALL saturate at 2^CTR_WIDTH-1 and at 0.
REQ-024 Outputs SHALL be registered: an update accepted for direct write in cycle t SHALL appear on its bank's write port in cycle t+1 for exactly one cycle.
REQ-025 Per-cycle bank allocation SHALL be in this priority order: first the FIFO head entry, which pops if it is valid; then requests in ascending port order, each granted if its bank is still free.
REQ-026 Only the FIFO head SHALL be eligible for a write in a given cycle; at most one pop per cycle.
REQ-027 Requests denied a bank SHALL be pushed into the FIFO in ascending port order, up to the free slot count.
REQ-028 Free slots SHALL be computed after this cycle's pop.
REQ-029 Requests exceeding the free slot count SHALL be dropped, and dropCount SHALL increase by the number dropped, saturating at 0xFFFF.
REQ-030 The FIFO SHALL store the computed value, not reqPrev.
REQ-031 FIFO pointers SHALL wrap modulo QUEUE_DEPTH; an occupancy counter SHALL distinguish full from empty.
REQ-032 Same-index requests in one cycle SHALL be handled independently (each writes its own computed value, with later grant order winning in the PHT); no merging.
REQ-033 phtWE SHALL be low for banks with no grant; phtWA and phtWV are don't-care when phtWE is low.

Reset
REQ-034 Asserting rst low SHALL asynchronously force the FSM to INIT, the init index to 0, the FIFO to empty, all phtWE to 0, initDone to 0 and dropCount to 0.
REQ-035 Reset asserted mid-INIT or mid-RUN SHALL discard FIFO contents, and initialization SHALL restart at index 0 after deassertion.
REQ-036 The first INIT write SHALL appear in the first clock edge after rst deasserts.

Verification
REQ-037 Release reset with default parameters -> 512 INIT cycles writing bank0 even indices and bank1 odd indices, each with value 2 -> initDone=1 in the next cycle, no drops.
REQ-038 In RUN, port0 {index 5, taken=1, prev=3} and port1 {index 6, taken=0, prev=0} -> next cycle bank1 gets WA 5, WV 3 and bank0 gets WA 6, WV 0.
REQ-039 Port0 index 4 and port1 index 8, same cycle -> bank0 writes 4 in t+1; index 8 is queued and written in t+2 with no new requests.
REQ-040 Bank-0 conflicts every cycle for 6 cycles -> FIFO fills to 4, subsequent excess requests are dropped, dropCount increments exactly by the dropped count, and the FIFO drains in order afterwards.
REQ-041 Assert rst low while the FIFO holds 3 entries -> all phtWE low immediately, initDone=0, dropCount=0; after release INIT restarts at index 0 and no queued entry is ever written.
